adder_bist: RTL and testbench
=============================

# adder_bist

Synthesizable self-test controller that drives an external adder under test (default: the 1-bit half adder) through its full input space and checks every response. It replaces the simulation-only stimulus/monitor bench with hardware that runs on the board, so the same adder can be verified in silicon/FPGA. It connects between the adder's operand inputs and sum/carry outputs, and reports pass/fail, error count and the first failing vector.

## Interface
Parameters:
- WIDTH, 1, operand width of the adder under test. Valid range is 1..4.
- SETTLE, 2, number of cycles a vector is held before the response is sampled. Must be ≥1.

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin a run; ignored while busy
- a  output  WIDTH  operand A driven to the adder; registered
- b  output  WIDTH  operand B driven to the adder; registered
- sum  input  WIDTH  sum returned by the adder
- carry  input  1  carry returned by the adder
- busy  output  1  run in progress (APPLY or CHECK)
- done  output  1  run complete; held until the next accepted start
- pass  output  1  valid while done=1; 1 iff err_count==0
- err_count  output  2*WIDTH+1  number of mismatching vectors in the current run
- first_fail  output  2*WIDTH  vector index {a,b} of the first mismatch; 0 if none

## Operation
- Vector index vec has 2*WIDTH bits and walks from 0 to N-1, where N=2^(2*WIDTH). The outputs are driven as {a,b}=vec, with a in the MSBs.
- Expected response: {carry,sum} = a+b, computed at WIDTH+1 bits with no truncation. For WIDTH=1 this is sum=a^b, carry=a&b.
- States:
  - IDLE: a=b=0, busy=0. If start=1, clear err_count and first_fail, set vec=0, clear done, and go to APPLY.
  - APPLY: a/b hold vec. A settle counter runs for SETTLE cycles, then the block goes to CHECK.
  - CHECK: a/b still hold vec. Compare the sampled {carry,sum} with the expected value. On a mismatch, increment err_count; if this is the first mismatch (err_count was 0), load first_fail=vec. If vec==N-1, go to DONE; otherwise vec++ and go to APPLY.
  - DONE: a=b=0, busy=0, done=1, pass=(err_count==0). Results are held. If start=1, clear the results and restart exactly as from IDLE.
- err_count cannot overflow, since its maximum value N fits in 2*WIDTH+1 bits. No saturation logic is needed.
- start is ignored in APPLY and CHECK. A run cannot be aborted except by reset.
- Reset at any point, including mid-run, forces IDLE immediately. All outputs go to 0 (a, b, busy, done, pass, err_count, first_fail) and vec goes to 0.

## Timing
- Edge T0 is the rising edge where start=1 is sampled in IDLE or DONE. From T0+ onward: busy=1, done=0, and a/b = vector 0.
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in APPLY plus 1 cycle in CHECK. The response is sampled at the closing edge of CHECK.
- Vector k is driven from edge T0+k*(SETTLE+1) until edge T0+(k+1)*(SETTLE+1).
- done rises and busy falls at edge T0+N*(SETTLE+1). For WIDTH=1 and SETTLE=2 this is T0+12. a/b return to 0 on the same edge.
- err_count and first_fail update on the CHECK closing edge of the failing vector.
- pass is combinationally derived from done and err_count. It is never 1 while done=0.
- The adder under test is combinational. Because SETTLE≥1, it always gets at least one full cycle to settle before sampling.

## Test plan
- Golden half adder, WIDTH=1, SETTLE=2: pulse start. Required: a/b step through 00,01,10,11, with 3 cycles per vector. done=1 at T0+12 with pass=1, err_count=0, first_fail=0.
- Carry stuck-at-0 fault: the only mismatch is vector 3 (a=1,b=1). Required: err_count=1, first_fail=3, pass=0.
- Sum inverted on every vector: required err_count=4, first_fail=0, pass=0.
- Start pulses while busy, at T0+2 and T0+7: both ignored. The run completes at T0+12 with results identical to the golden case. A later start from DONE clears done on the next edge and repeats the run.
- Assert rst_n=0 asynchronously while vector 2 is applied, between clock edges. Required: all outputs are 0 immediately. After release the block stays in IDLE until start, and a fresh run passes.
- WIDTH=2, SETTLE=1, golden 2-bit adder: 16 vectors, done at T0+32, pass=1. Injecting sum[1] stuck-at-1 gives err_count=8 and first_fail=0.

Source files
------------

// File: rtl/adder_bist.sv
// Built-in self-test controller for a combinational adder. It walks the adder
// through every {a,b} operand pair and reports the error count and first failing vector.
module adder_bist #(
   parameter int WIDTH  = 1,
   parameter int SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [WIDTH-1:0]     a,
   output logic [WIDTH-1:0]     b,
   input  logic [WIDTH-1:0]     sum,
   input  logic                 carry,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH:0]     err_count,
   output logic [2*WIDTH-1:0]   first_fail
);

   // state   | meaning
   // S_IDLE  | operands parked at 0, waiting for start
   // S_APPLY | current vector driven, settle timer counting down
   // S_CHECK | response sampled and compared on the closing edge
   // S_DONE  | results held, start re-arms a fresh run

   localparam int VEC_W = 2*WIDTH;
   localparam int ERR_W = 2*WIDTH+1;
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [VEC_W-1:0] VEC_LAST = '1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE-1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [VEC_W-1:0]  vec_q, vec_d;
   logic [VEC_W-1:0]  ab_q, ab_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [VEC_W-1:0]  ff_q, ff_d;

   logic [WIDTH:0]    expected;
   logic [WIDTH:0]    response;
   logic              mismatch;

   // Reference sum is formed from the vector register rather than the a/b
   // outputs, so it is the intended operands that get checked.
   assign expected = {1'b0, vec_q[VEC_W-1:WIDTH]} + {1'b0, vec_q[WIDTH-1:0]};
   assign response = {carry, sum};
   assign mismatch = (response != expected);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         ab_q    <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         ff_q    <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         ab_q    <= ab_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      ab_d    = ab_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ff_d    = ff_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_APPLY;
               vec_d   = '0;
               ab_d    = '0;
               cnt_d   = CNT_LOAD;
               err_d   = '0;
               ff_d    = '0;
            end
         end

         S_APPLY: begin
            if (cnt_q == '0) begin
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_CHECK: begin
            if (mismatch) begin
               err_d = err_q + ERR_W'(1);
               if (err_q == '0) begin
                  ff_d = vec_q;
               end
            end
            if (vec_q == VEC_LAST) begin
               state_d = S_DONE;
               ab_d    = '0;
            end else begin
               state_d = S_APPLY;
               vec_d   = vec_q + VEC_W'(1);
               ab_d    = vec_q + VEC_W'(1);
               cnt_d   = CNT_LOAD;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign a          = ab_q[VEC_W-1:WIDTH];
   assign b          = ab_q[WIDTH-1:0];
   assign busy       = (state_q == S_APPLY) || (state_q == S_CHECK);
   assign done       = (state_q == S_DONE);
   assign pass       = done && (err_q == '0);
   assign err_count  = err_q;
   assign first_fail = ff_q;

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist: a 1-bit/SETTLE=2 and a 2-bit/SETTLE=1
// instance, each driving a behavioural adder with selectable fault injection.
module tb_adder_bist;

   localparam int M_GOLD     = 0;
   localparam int M_CARRY_0  = 1;
   localparam int M_SUM_INV  = 2;
   localparam int M_RAND     = 3;
   localparam int M_SUM1_1   = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start1 = 1'b0;
   logic start2 = 1'b0;

   logic [0:0] a1, b1, sum1;
   logic       carry1, busy1, done1, pass1;
   logic [2:0] err1;
   logic [1:0] ff1;

   logic [1:0] a2, b2, sum2;
   logic       carry2, busy2, done2, pass2;
   logic [4:0] err2;
   logic [3:0] ff2;

   int mode1 = M_GOLD;
   int mode2 = M_GOLD;
   logic [1:0] mask1 [4];
   logic [2:0] mask2 [16];
   logic [1:0] resp1;
   logic [2:0] resp2;

   int sel = 0;
   logic [3:0] ab_cur;
   logic       busy_cur, done_cur, pass_cur;
   logic [4:0] err_cur;
   logic [3:0] ff_cur;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   adder_bist #(.WIDTH(1), .SETTLE(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .a(a1), .b(b1), .sum(sum1), .carry(carry1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .first_fail(ff1)
   );

   adder_bist #(.WIDTH(2), .SETTLE(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2),
      .a(a2), .b(b2), .sum(sum2), .carry(carry2),
      .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .first_fail(ff2)
   );

   // Adders under test: true sum, optionally corrupted by the selected fault.
   always_comb begin
      resp1 = {1'b0, a1} + {1'b0, b1};
      case (mode1)
         M_CARRY_0: resp1[1] = 1'b0;
         M_SUM_INV: resp1[0] = ~resp1[0];
         M_RAND:    resp1 = resp1 ^ mask1[{a1, b1}];
         default: ;
      endcase
   end
   assign {carry1, sum1} = resp1;

   always_comb begin
      resp2 = {1'b0, a2} + {1'b0, b2};
      case (mode2)
         M_SUM1_1: resp2[1] = 1'b1;
         M_RAND:   resp2 = resp2 ^ mask2[{a2, b2}];
         default: ;
      endcase
   end
   assign {carry2, sum2} = resp2;

   always_comb begin
      if (sel == 1) begin
         ab_cur   = {a2, b2};
         busy_cur = busy2;
         done_cur = done2;
         pass_cur = pass2;
         err_cur  = err2;
         ff_cur   = ff2;
      end else begin
         ab_cur   = {2'b00, a1, b1};
         busy_cur = busy1;
         done_cur = done1;
         pass_cur = pass1;
         err_cur  = {2'b00, err1};
         ff_cur   = {2'b00, ff1};
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_start(input int s, input logic v);
      if (s == 1) start2 = v;
      else start1 = v;
   endtask

   // One full run on instance s; every cycle is checked against the
   // vector schedule k/(SETTLE+1), then the final results against exp_*.
   task automatic run(input int s, input int exp_err, input int exp_ff, input bit poke);
      int n_vec, per, total;
      n_vec = (s == 1) ? 16 : 4;
      per   = (s == 1) ? 2 : 3;
      total = n_vec * per;
      sel   = s;
      @(negedge clk);
      drive_start(s, 1'b1);
      @(negedge clk);
      drive_start(s, 1'b0);
      for (int k = 0; k < total; k++) begin
         check("busy", busy_cur, 1);
         check("done_low", done_cur, 0);
         check("pass_low", pass_cur, 0);
         check("vec", ab_cur, k / per);
         if (k == 0) begin
            check("err_clr", err_cur, 0);
            check("ff_clr", ff_cur, 0);
         end
         drive_start(s, poke && (k == 1 || k == 6));
         @(negedge clk);
      end
      drive_start(s, 1'b0);
      check("done", done_cur, 1);
      check("busy_end", busy_cur, 0);
      check("ab_end", ab_cur, 0);
      check("err_count", err_cur, exp_err);
      check("first_fail", ff_cur, exp_ff);
      check("pass", pass_cur, exp_err == 0);
   endtask

   // Random per-vector corruption; expected results come from the mask table alone.
   task automatic rand_run(input int s);
      int n_vec, e, f, m;
      n_vec = (s == 1) ? 16 : 4;
      e = 0;
      f = 0;
      for (int v = 0; v < n_vec; v++) begin
         m = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (s == 1) ? 7 : 3) : 0;
         if (s == 1) mask2[v] = 3'(m);
         else mask1[v] = 2'(m);
         if (m != 0) begin
            if (e == 0) f = v;
            e++;
         end
      end
      if (s == 1) mode2 = M_RAND;
      else mode1 = M_RAND;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(s, e, f, 1'($urandom_range(0, 1)));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ab"}, ab_cur, 0);
      check({tag, "_busy"}, busy_cur, 0);
      check({tag, "_done"}, done_cur, 0);
      check({tag, "_pass"}, pass_cur, 0);
      check({tag, "_err"}, err_cur, 0);
      check({tag, "_ff"}, ff_cur, 0);
   endtask

   initial begin
      for (int v = 0; v < 4; v++) mask1[v] = '0;
      for (int v = 0; v < 16; v++) mask2[v] = '0;

      repeat (2) @(negedge clk);
      sel = 0;
      #1 check_all_zero("rst1");
      sel = 1;
      #1 check_all_zero("rst2");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      sel = 0;
      check_all_zero("idle1");

      mode1 = M_GOLD;
      run(0, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      check("done_hold", done_cur, 1);
      check("pass_hold", pass_cur, 1);

      mode1 = M_CARRY_0;
      run(0, 1, 3, 1'b0);
      mode1 = M_SUM_INV;
      run(0, 4, 0, 1'b0);
      mode1 = M_GOLD;
      run(0, 0, 0, 1'b1);
      run(0, 0, 0, 1'b0);

      // Asynchronous reset in the middle of vector 2.
      sel = 0;
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (7) @(negedge clk);
      check("pre_rst_vec", ab_cur, 2);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_all_zero("post_rst");
      run(0, 0, 0, 1'b0);

      mode2 = M_GOLD;
      run(1, 0, 0, 1'b0);
      mode2 = M_SUM1_1;
      run(1, 8, 0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         rand_run(0);
         rand_run(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
